// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the s1/s0 select lines of a downstream 4:1 mux.
// Grants are dwell-bounded under contention and separated by a one-cycle gap.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic       s0,
  output logic       s1,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       switch_p
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       sel_r, sel_s;
  logic [1:0]       last_r, last_s;
  logic [3:0]       gnt_r, gnt_s;
  logic             valid_r, valid_s;
  logic             sw_r, sw_s;
  logic [CNT_W-1:0] dwell_r, dwell_s;
  logic [2:0]       pick_s;
  logic             others_s;

  // Returns {found, index}: first set request searching last+1, last+2, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = last + k[1:0];
      if (r[c]) begin
        res = {1'b1, c};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-output logic; en low overrides every transition.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    last_s   = last_r;
    gnt_s    = gnt_r;
    valid_s  = valid_r;
    sw_s     = 1'b0;
    dwell_s  = dwell_r;
    pick_s   = rr_pick(req, last_r);
    others_s = |(req & ~gnt_r);
    if (!en) begin
      state_s = ST_IDLE;
      gnt_s   = 4'b0000;
      valid_s = 1'b0;
      dwell_s = '0;
    end else begin
      case (state_r)
        ST_GRANT: begin
          if (!req[sel_r] || ((dwell_r == DWELL_MAX) && others_s)) begin
            state_s = ST_GAP;
            gnt_s   = 4'b0000;
            valid_s = 1'b0;
            dwell_s = '0;
          end else if (dwell_r != DWELL_MAX) begin
            dwell_s = dwell_r + DWELL_ONE;
          end else begin
            dwell_s = dwell_r;
          end
        end
        ST_IDLE, ST_GAP: begin
          if (pick_s[2]) begin
            state_s = ST_GRANT;
            sel_s   = pick_s[1:0];
            last_s  = pick_s[1:0];
            gnt_s   = 4'b0001 << pick_s[1:0];
            valid_s = 1'b1;
            sw_s    = 1'b1;
            dwell_s = DWELL_ONE;
          end else begin
            state_s = ST_IDLE;
            gnt_s   = 4'b0000;
            valid_s = 1'b0;
            dwell_s = '0;
          end
        end
        default: begin
          state_s = ST_IDLE;
          gnt_s   = 4'b0000;
          valid_s = 1'b0;
          dwell_s = '0;
        end
      endcase
    end
  end

  // State and output registers; reset leaves last=3 so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sel_r   <= 2'b00;
      last_r  <= 2'd3;
      gnt_r   <= 4'b0000;
      valid_r <= 1'b0;
      sw_r    <= 1'b0;
      dwell_r <= '0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      last_r  <= last_s;
      gnt_r   <= gnt_s;
      valid_r <= valid_s;
      sw_r    <= sw_s;
      dwell_r <= dwell_s;
    end
  end

  assign s0        = sel_r[0];
  assign s1        = sel_r[1];
  assign gnt       = gnt_r;
  assign gnt_valid = valid_r;
  assign switch_p  = sw_r;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed plus randomized bench for mux_sel_arbiter against a channel-ownership
// reference model, with a behavioural 4:1 mux on the select lines.
module tb_mux_sel_arbiter;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;
  logic       s0, s1, gnt_valid, switch_p;
  logic [3:0] gnt;
  logic [7:0] data [4];
  logic [7:0] mux_out;

  int checks = 0;
  int passes = 0;

  // reference model: who owns the mux, and bookkeeping around it
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_dwell = 0;
  bit m_sw    = 1'b0;

  bit         prev_valid = 1'b0;
  logic [1:0] prev_sel   = 2'b00;
  int         sw_count;
  int         order_q [$];

  mux_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .s0(s0), .s1(s1), .gnt(gnt), .gnt_valid(gnt_valid), .switch_p(switch_p)
  );

  assign mux_out = data[{s1, s0}];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input bit r, input bit e, input logic [3:0] q);
    bit compete;
    if (r) begin
      m_owner = -1; m_last = 3; m_sel = 0; m_dwell = 0; m_sw = 1'b0;
    end else if (!e) begin
      m_owner = -1; m_dwell = 0; m_sw = 1'b0;
    end else if (m_owner >= 0) begin
      m_sw = 1'b0;
      compete = 1'b0;
      for (int i = 0; i < 4; i++) if (i != m_owner && q[i]) compete = 1'b1;
      if (!q[m_owner] || (m_dwell >= HOLD && compete)) begin
        m_owner = -1; m_dwell = 0;
      end else begin
        m_dwell = (m_dwell + 1 > HOLD) ? HOLD : m_dwell + 1;
      end
    end else begin
      m_sw = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!m_sw && q[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_sw = 1'b1;
        end
      end
      if (m_sw) begin
        m_sel = m_owner; m_last = m_owner; m_dwell = 1;
      end
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic step(input bit r, input bit e, input logic [3:0] q);
    int ch;
    @(negedge clk);
    rst = r; en = e; req = q;
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    @(posedge clk);
    model(r, e, q);
    #1;
    chk("gnt", 32'(gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("sel", 32'({s1, s0}), 32'(m_sel));
    chk("switch_p", 32'(switch_p), 32'(m_sw));
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_valid_or", 32'(gnt_valid), 32'(|gnt));
    if (gnt_valid === 1'b1) begin
      ch = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) ch = i;
      chk("inv_gnt_sel", 32'(gnt[{s1, s0}]), 32'd1);
      chk("mux_out", 32'(mux_out), 32'(data[ch]));
      if (prev_valid) chk("inv_sel_stable", 32'({s1, s0}), 32'(prev_sel));
    end
    if (switch_p === 1'b1) begin
      sw_count++;
      order_q.push_back(m_owner);
    end
    prev_valid = (gnt_valid === 1'b1);
    prev_sel   = {s1, s0};
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    // reset state
    step(1'b1, 1'b0, 4'b0000);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'({s1, s0}), 32'd0);

    // 1: single request on ch0
    step(1'b0, 1'b1, 4'b0001);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_sw", 32'(switch_p), 32'd1);
    step(1'b0, 1'b1, 4'b0001);
    chk("t1_sw_drop", 32'(switch_p), 32'd0);

    // 2: all requesting -> rotation with period HOLD+1
    step(1'b1, 1'b0, 4'b0000);
    sw_count = 0; order_q.delete();
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 4'b1111);
    chk("t2_switches", 32'(sw_count), 32'd7);
    for (int i = 0; i < order_q.size(); i++) chk("t2_order", 32'(order_q[i]), 32'(i % 4));

    // 3: ch2 drops after 3 cycles, ch1 waiting
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0100);
    chk("t3_gnt2", 32'(gnt), 32'h4);
    step(1'b0, 1'b1, 4'b0010);
    chk("t3_gap", 32'(gnt_valid), 32'd0);
    chk("t3_gap_sel", 32'({s1, s0}), 32'd2);
    step(1'b0, 1'b1, 4'b0010);
    chk("t3_gnt1", 32'(gnt), 32'h2);
    chk("t3_sel1", 32'({s1, s0}), 32'd1);

    // 4: lone ch3 holds indefinitely
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b1000);
    sw_count = 0;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 4'b1000);
    chk("t4_switches", 32'(sw_count), 32'd0);
    chk("t4_gnt", 32'(gnt), 32'h8);

    // 5: en low mid-grant, then restart from last+1
    step(1'b0, 1'b0, 4'b1111);
    chk("t5_gnt_off", 32'(gnt), 32'd0);
    step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 4'b1111);
    chk("t5_regrant", 32'(gnt), 32'h1);

    // 6: reset during grant on ch1, then search restarts at 0
    step(1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0010);
    step(1'b0, 1'b1, 4'b0010);
    step(1'b1, 1'b1, 4'b1111);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_sel", 32'({s1, s0}), 32'd0);
    step(1'b0, 1'b1, 4'b1111);
    chk("t6_first", 32'(gnt), 32'h1);

    // sweep all request patterns with both en values
    for (int e = 0; e < 2; e++)
      for (int p = 0; p < 16; p++)
        for (int c = 0; c < 3; c++) step(1'b0, e[0], p[3:0]);

    // randomized traffic, occasional en drop and reset
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0), 4'($urandom));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
